// File: rtl/mux_reg_ctrl.sv
// Sequencing controller for a mux-based D-flop register: accepts one command at
// a time and drives the hold/load/clear/shift select of every flop.
module mux_reg_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic             ser_in,
    output logic             ser_out,
    output logic             ser_valid,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SHIFT = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_EXEC  = 2'b01,
        ST_SHIFT = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        SEL_HOLD  = 2'b00,
        SEL_LOAD  = 2'b01,
        SEL_SHIFT = 2'b10,
        SEL_CLEAR = 2'b11
    } sel_e;

    state_e           state_q, state_d;
    sel_e             sel;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] q_q, q_d;

    // State, counter, latched command and register flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            data_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            data_q  <= data_d;
            q_q     <= q_d;
        end
    end

    // Next-state and flop select
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        data_d  = data_q;
        sel     = SEL_HOLD;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    unique case (cmd_op)
                        OP_NOP:   state_d = ST_DONE;
                        OP_LOAD,
                        OP_CLEAR: state_d = ST_EXEC;
                        OP_SHIFT: begin
                            if (cmd_len != '0) begin
                                state_d = ST_SHIFT;
                                cnt_d   = cmd_len;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                        default:  state_d = ST_IDLE;
                    endcase
                end
            end
            ST_EXEC: begin
                if (op_q == OP_LOAD) begin
                    sel = SEL_LOAD;
                end else if (op_q == OP_CLEAR) begin
                    sel = SEL_CLEAR;
                end
                state_d = ST_DONE;
            end
            ST_SHIFT: begin
                sel   = SEL_SHIFT;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-flop next-state mux
    always_comb begin
        q_d = q_q;
        unique case (sel)
            SEL_HOLD:  q_d = q_q;
            SEL_LOAD:  q_d = data_q;
            SEL_SHIFT: q_d = {q_q[WIDTH-2:0], ser_in};
            SEL_CLEAR: q_d = '0;
            default:   q_d = q_q;
        endcase
    end

    assign q         = q_q;
    assign ser_out   = q_q[WIDTH-1];
    assign cmd_ready = (state_q == ST_IDLE) && rst_n;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign ser_valid = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_mux_reg_ctrl.sv
// Directed bench for mux_reg_ctrl: vector table plus multi-cycle sequences.
module tb_mux_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic [3:0] cmd_len;
    logic       ser_in;
    logic       ser_out;
    logic       ser_valid;
    logic [7:0] q;
    logic       busy;
    logic       done;

    int n_vec = 0;
    int n_bad = 0;

    mux_reg_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_len   (cmd_len),
        .ser_in    (ser_in),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .q         (q),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic [1:0] op;
        logic [7:0] d;
        logic [3:0] l;
        logic       si;
        logic [7:0] eq;
        logic       erdy;
        logic       ebsy;
        logic       edn;
        logic       esv;
        logic       eso;
    } vec_t;

    localparam int unsigned NVEC = 19;
    vec_t tbl [NVEC];

    task automatic drive(input logic r, input logic v, input logic [1:0] op,
                         input logic [7:0] d, input logic [3:0] l, input logic si);
        rst_n = r; cmd_valid = v; cmd_op = op; cmd_data = d; cmd_len = l; ser_in = si;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Steps until done, counting ser_valid cycles; a blown budget is a failure
    task automatic wait_done(input int budget, output int sv_cnt);
        bit seen;
        seen   = 0;
        sv_cnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (ser_valid) sv_cnt++;
            if (done) seen = 1;
            cmd_valid = 1'b0;
        end
        chk("wait_done_timeout", 16'(seen), 16'd1);
    endtask

    int  svc;
    bit  saw_done;

    initial begin
        //            r    v    op     d      l     si   eq     rdy  bsy  dn   sv   so
        tbl[0]  = '{1'b0,1'b1,2'b01,8'hFF,4'd0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[1]  = '{1'b0,1'b1,2'b01,8'hFF,4'd0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b0,1'b0};
        tbl[2]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'h00,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[3]  = '{1'b1,1'b1,2'b01,8'hA5,4'd0,1'b0,8'h00,1'b0,1'b1,1'b0,1'b0,1'b0};
        tbl[4]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b0,1'b1,1'b1,1'b0,1'b1};
        tbl[5]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[6]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[7]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[8]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[9]  = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'hA5,1'b1,1'b0,1'b0,1'b0,1'b1};
        tbl[10] = '{1'b1,1'b1,2'b10,8'h00,4'd3,1'b1,8'hA5,1'b0,1'b1,1'b0,1'b1,1'b1};
        tbl[11] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b1,8'h4B,1'b0,1'b1,1'b0,1'b1,1'b0};
        tbl[12] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b1,8'h97,1'b0,1'b1,1'b0,1'b1,1'b1};
        tbl[13] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b1,8'h2F,1'b0,1'b1,1'b1,1'b0,1'b0};
        tbl[14] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'h2F,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[15] = '{1'b1,1'b1,2'b10,8'h00,4'd0,1'b1,8'h2F,1'b0,1'b1,1'b1,1'b0,1'b0};
        tbl[16] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'h2F,1'b1,1'b0,1'b0,1'b0,1'b0};
        tbl[17] = '{1'b1,1'b1,2'b00,8'h00,4'd0,1'b0,8'h2F,1'b0,1'b1,1'b1,1'b0,1'b0};
        tbl[18] = '{1'b1,1'b0,2'b00,8'h00,4'd0,1'b0,8'h2F,1'b1,1'b0,1'b0,1'b0,1'b0};

        drive(1'b0, 1'b1, 2'b01, 8'hFF, 4'd0, 1'b0);
        #2;
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(tbl[i].r, tbl[i].v, tbl[i].op, tbl[i].d, tbl[i].l, tbl[i].si);
            step();
            chk($sformatf("vec%0d{q,rdy,bsy,dn,sv,so}", i),
                16'({q, cmd_ready, busy, done, ser_valid, ser_out}),
                16'({tbl[i].eq, tbl[i].erdy, tbl[i].ebsy, tbl[i].edn, tbl[i].esv, tbl[i].eso}));
        end

        // Long shift: len exceeds width, ser_in=0 flushes 8'hFF to zero
        drive(1'b1, 1'b1, 2'b01, 8'hFF, 4'd0, 1'b0);
        wait_done(10, svc);
        step();
        chk("load_ff", 16'(q), 16'h00FF);
        drive(1'b1, 1'b1, 2'b10, 8'h00, 4'd10, 1'b0);
        wait_done(20, svc);
        chk("len10_q", 16'(q), 16'h0000);
        chk("len10_sv_cycles", 16'(svc), 16'd10);
        step();

        // CLEAR from 3C while a LOAD 8'h11 is offered during busy cycles
        drive(1'b1, 1'b1, 2'b01, 8'h3C, 4'd0, 1'b0);
        wait_done(10, svc);
        step();
        chk("load_3c", 16'(q), 16'h003C);
        drive(1'b1, 1'b1, 2'b11, 8'h00, 4'd0, 1'b0);
        step();
        drive(1'b1, 1'b1, 2'b01, 8'h11, 4'd0, 1'b0);
        chk("clear_exec_ready", 16'(cmd_ready), 16'd0);
        step();
        chk("clear_q_done", 16'({q, done}), 16'({8'h00, 1'b1}));
        step();
        cmd_valid = 1'b0;
        chk("ignored_load_idle", 16'({q, busy}), 16'({8'h00, 1'b0}));
        step();
        chk("ignored_load_hold", 16'({q, busy, done}), 16'({8'h00, 1'b0, 1'b0}));

        // Reset in the middle of a 6-cycle shift
        drive(1'b1, 1'b1, 2'b10, 8'h00, 4'd6, 1'b1);
        step();
        cmd_valid = 1'b0;
        step();
        step();
        chk("pre_reset_q", 16'({q, ser_valid}), 16'({8'h03, 1'b1}));
        rst_n = 1'b0;
        step();
        chk("mid_reset_outs", 16'({q, cmd_ready, busy, done, ser_valid}),
            16'({8'h00, 1'b0, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        saw_done = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done) saw_done = 1;
        end
        chk("post_reset_ready", 16'({q, cmd_ready, busy}), 16'({8'h00, 1'b1, 1'b0}));
        chk("post_reset_no_done", 16'(saw_done), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
